// File: rtl/avmm_sample_mem_slave.sv
// avmm_sample_mem_slave
// Avalon-MM style memory responder holding x samples, h coefficients and
// y results in one word array. Two independent ports (read and write), each
// with its own small FSM that inserts a fixed number of wait-request cycles.
//
// Optional feature: define AVMM_SLV_CNT_EN to add completed-transfer counters.
//
// Ports:
//   iClk, iRst        clock, synchronous active-high reset
//   iAddress_Read     read word address
//   iRead             read request
//   oReadData         read data (registered, valid in R_ACK, held until next latch)
//   oWait_Read        read wait-request (combinational)
//   iAddress_Write    write word address
//   iWrite            write request
//   iWriteData        write data
//   oWait_Write       write wait-request (combinational)
//   oErr              sticky out-of-range access flag
//   oRdCount/oWrCount completed in-range transfers, saturating (AVMM_SLV_CNT_EN only)
//
// state  | meaning
// R_IDLE | no read in progress; a request loads the wait counter
// R_WAIT | counting down; latch data when the counter reaches 0
// R_ACK  | wait-request low, read completes this cycle
// W_IDLE | no write in progress; a request loads the wait counter
// W_WAIT | counting down; go to W_ACK when the counter reaches 0
// W_ACK  | wait-request low, array written on the edge ending this cycle

module avmm_sample_mem_slave #(
    parameter int          DATA_W     = 32,
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          READ_WAIT  = 2,
    parameter int          WRITE_WAIT = 1
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic [31:0]       iAddress_Read,
    input  logic              iRead,
    output logic [DATA_W-1:0] oReadData,
    output logic              oWait_Read,
    input  logic [31:0]       iAddress_Write,
    input  logic              iWrite,
    input  logic [DATA_W-1:0] iWriteData,
    output logic              oWait_Write,
    output logic              oErr
`ifdef AVMM_SLV_CNT_EN
    ,
    output logic [15:0]       oRdCount,
    output logic [15:0]       oWrCount
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_WAIT = 2'd1;
    localparam logic [1:0] R_ACK  = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_WAIT = 2'd1;
    localparam logic [1:0] W_ACK  = 2'd2;

    localparam logic [3:0] RD_WAIT_LD = 4'(READ_WAIT);
    localparam logic [3:0] WR_WAIT_LD = 4'(WRITE_WAIT);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]        r_rd_state;
    logic [3:0]        r_rd_cnt;
    logic [DATA_W-1:0] r_rd_data;
    logic [1:0]        r_wr_state;
    logic [3:0]        r_wr_cnt;
    logic              r_err;

    logic [31:0]       w_rd_off;
    logic [31:0]       w_wr_off;
    logic              w_rd_in;
    logic              w_wr_in;
    logic              w_rd_latch;
    logic              w_wr_commit;

    // Offset from the base wraps modulo 2**32, so addresses below the base
    // land far out of range rather than aliasing into the array.
    assign w_rd_off = iAddress_Read - BASE_ADDR;
    assign w_wr_off = iAddress_Write - BASE_ADDR;
    assign w_rd_in  = ((w_rd_off >> ADDR_W) == 32'd0);
    assign w_wr_in  = ((w_wr_off >> ADDR_W) == 32'd0);

    assign w_rd_latch  = (r_rd_state == R_WAIT) && iRead && (r_rd_cnt == 4'd0);
    assign w_wr_commit = (r_wr_state == W_ACK);

    assign oWait_Read  = iRead  && (r_rd_state != R_ACK);
    assign oWait_Write = iWrite && (r_wr_state != W_ACK);
    assign oReadData   = r_rd_data;
    assign oErr        = r_err;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_rd_state <= R_IDLE;
            r_rd_cnt   <= 4'd0;
            r_rd_data  <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (iRead) begin
                        r_rd_cnt   <= RD_WAIT_LD;
                        r_rd_state <= R_WAIT;
                    end
                end
                R_WAIT: begin
                    // Master dropping iRead mid-wait is a protocol violation: abort silently.
                    if (!iRead) begin
                        r_rd_state <= R_IDLE;
                    end else if (r_rd_cnt == 4'd0) begin
                        r_rd_data  <= w_rd_in ? r_mem[w_rd_off[ADDR_W-1:0]] : '0;
                        r_rd_state <= R_ACK;
                    end else begin
                        r_rd_cnt <= r_rd_cnt - 4'd1;
                    end
                end
                R_ACK:   r_rd_state <= R_IDLE;
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_wr_state <= W_IDLE;
            r_wr_cnt   <= 4'd0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (iWrite) begin
                        r_wr_cnt   <= WR_WAIT_LD;
                        r_wr_state <= W_WAIT;
                    end
                end
                W_WAIT: begin
                    if (!iWrite) begin
                        r_wr_state <= W_IDLE;
                    end else if (r_wr_cnt == 4'd0) begin
                        r_wr_state <= W_ACK;
                    end else begin
                        r_wr_cnt <= r_wr_cnt - 4'd1;
                    end
                end
                W_ACK:   r_wr_state <= W_IDLE;
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    // Array is never cleared. A read latch on the same edge sees the old word
    // because both use non-blocking updates (read-before-write).
    always_ff @(posedge iClk) begin
        if (!iRst && w_wr_commit && w_wr_in) begin
            r_mem[w_wr_off[ADDR_W-1:0]] <= iWriteData;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_err <= 1'b0;
        end else if ((w_rd_latch && !w_rd_in) || (w_wr_commit && !w_wr_in)) begin
            r_err <= 1'b1;
        end
    end

`ifdef AVMM_SLV_CNT_EN
    logic        r_rd_ok;
    logic [15:0] r_rd_count;
    logic [15:0] r_wr_count;

    // Range result of the latched read, so R_ACK counts only in-range reads
    // even if the master changes the address afterwards.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_rd_ok <= 1'b0;
        end else if (w_rd_latch) begin
            r_rd_ok <= w_rd_in;
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_rd_count <= 16'd0;
            r_wr_count <= 16'd0;
        end else begin
            if ((r_rd_state == R_ACK) && r_rd_ok && (r_rd_count != 16'hFFFF)) begin
                r_rd_count <= r_rd_count + 16'd1;
            end
            if (w_wr_commit && w_wr_in && (r_wr_count != 16'hFFFF)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign oRdCount = r_rd_count;
    assign oWrCount = r_wr_count;
`endif

endmodule

// File: tb/tb_avmm_sample_mem_slave.sv
// Scoreboard bench for avmm_sample_mem_slave. Two instances share stimulus:
// dut_a uses the default wait counts (read 2, write 1, base 0), dut_b uses
// zero waits and base 0x100. sel picks which instance sees the requests.
module tb_avmm_sample_mem_slave;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        rd;
    logic        wr;
    logic [31:0] addr_r;
    logic [31:0] addr_w;
    logic [31:0] wdata;

    logic [31:0] rdata_a, rdata_b;
    logic        wait_rd_a, wait_rd_b, wait_wr_a, wait_wr_b;
    logic        err_a, err_b;
`ifdef AVMM_SLV_CNT_EN
    logic [15:0] rcnt_a, wcnt_a, rcnt_b, wcnt_b;
`endif

    logic [31:0] m_rdata;
    logic        m_wait_rd;
    logic        m_wait_wr;
    logic        m_err;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [31:0] data;
        int          waits;
    } exp_t;

    exp_t q_rd[$];
    int   q_wr[$];
    int   rd_wc = 0;
    int   wr_wc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    avmm_sample_mem_slave #(
        .DATA_W(32), .ADDR_W(6), .BASE_ADDR(32'h0000_0000),
        .READ_WAIT(2), .WRITE_WAIT(1)
    ) dut_a (
        .iClk(clk), .iRst(rst),
        .iAddress_Read(addr_r), .iRead(rd && !sel),
        .oReadData(rdata_a), .oWait_Read(wait_rd_a),
        .iAddress_Write(addr_w), .iWrite(wr && !sel), .iWriteData(wdata),
        .oWait_Write(wait_wr_a), .oErr(err_a)
`ifdef AVMM_SLV_CNT_EN
        , .oRdCount(rcnt_a), .oWrCount(wcnt_a)
`endif
    );

    avmm_sample_mem_slave #(
        .DATA_W(32), .ADDR_W(6), .BASE_ADDR(32'h0000_0100),
        .READ_WAIT(0), .WRITE_WAIT(0)
    ) dut_b (
        .iClk(clk), .iRst(rst),
        .iAddress_Read(addr_r), .iRead(rd && sel),
        .oReadData(rdata_b), .oWait_Read(wait_rd_b),
        .iAddress_Write(addr_w), .iWrite(wr && sel), .iWriteData(wdata),
        .oWait_Write(wait_wr_b), .oErr(err_b)
`ifdef AVMM_SLV_CNT_EN
        , .oRdCount(rcnt_b), .oWrCount(wcnt_b)
`endif
    );

    assign m_rdata   = sel ? rdata_b   : rdata_a;
    assign m_wait_rd = sel ? wait_rd_b : wait_rd_a;
    assign m_wait_wr = sel ? wait_wr_b : wait_wr_a;
    assign m_err     = sel ? err_b     : err_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: counts wait cycles of each transfer and checks on its ACK cycle.
    always @(negedge clk) begin
        if (rst) begin
            rd_wc = 0;
            wr_wc = 0;
        end else begin
            if (rd) begin
                if (m_wait_rd) begin
                    rd_wc++;
                end else begin
                    if (q_rd.size() == 0) begin
                        check("rd_unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q_rd.pop_front();
                        check("rd_data", m_rdata, e.data);
                        check("rd_waits", 32'(rd_wc), 32'(e.waits));
                    end
                    rd_wc = 0;
                end
            end else begin
                rd_wc = 0;
            end
            if (wr) begin
                if (m_wait_wr) begin
                    wr_wc++;
                end else begin
                    if (q_wr.size() == 0) begin
                        check("wr_unexpected_ack", 32'd1, 32'd0);
                    end else begin
                        int ew;
                        ew = q_wr.pop_front();
                        check("wr_waits", 32'(wr_wc), 32'(ew));
                    end
                    wr_wc = 0;
                end
            end else begin
                wr_wc = 0;
            end
        end
    end

    // Drivers are entered just after a rising edge and return just after one.
    task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int w);
        bit done;
        exp_t e;
        e.data  = d;
        e.waits = w;
        q_rd.push_back(e);
        addr_r = a;
        rd     = 1'b1;
        done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!m_wait_rd) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("rd_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int w);
        bit done;
        q_wr.push_back(w);
        addr_w = a;
        wdata  = d;
        wr     = 1'b1;
        done   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!m_wait_wr) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("wr_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        addr_r = '0;
        addr_w = '0;
        wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rdata_a", rdata_a, 32'h0);
        check("rst_err_a", {31'd0, err_a}, 32'd0);
        check("rst_rdata_b", rdata_b, 32'h0);
        check("rst_err_b", {31'd0, err_b}, 32'd0);
`ifdef AVMM_SLV_CNT_EN
        check("rst_rcnt_a", {16'd0, rcnt_a}, 32'd0);
        check("rst_wcnt_a", {16'd0, wcnt_a}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Basic write/read round trip, dut_a (read 4 waits, write 3 waits)
        do_write(32'd3, 32'h0000_0012, 3);
        do_read(32'd3, 32'h0000_0012, 4);

        // Same-edge read latch and write commit on idx 5: read sees old value
        do_write(32'd5, 32'h0000_000A, 3);
        fork
            do_read(32'd5, 32'h0000_000A, 4);
            do_write(32'd5, 32'h0000_000B, 3);
        join
        do_read(32'd5, 32'h0000_000B, 4);

        // Out-of-range read, then in-range traffic still works with oErr sticky
        do_read(32'd64, 32'h0, 4);
        @(negedge clk);
        check("err_after_oor", {31'd0, m_err}, 32'd1);
        @(posedge clk);
        #1;
        do_write(32'd10, 32'h0000_0055, 3);
        do_read(32'd10, 32'h0000_0055, 4);
        do_write(32'd7, 32'h0000_0077, 3);
        @(negedge clk);
        check("err_sticky", {31'd0, m_err}, 32'd1);
        @(posedge clk);
        #1;

        // Reset while the write of 0xFF to idx 7 sits in W_WAIT
        addr_w = 32'd7;
        wdata  = 32'h0000_00FF;
        wr     = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        wr  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_err", {31'd0, m_err}, 32'd0);
        check("rstmid_wait_rd", {31'd0, m_wait_rd}, 32'd0);
        check("rstmid_wait_wr", {31'd0, m_wait_wr}, 32'd0);
        @(posedge clk);
        #1;
        do_read(32'd7, 32'h0000_0077, 4);
        do_read(32'd3, 32'h0000_0012, 4);

        // Zero-wait instance, base 0x100: idx 0 and idx 63 round trips
        sel = 1'b1;
        do_write(32'h100, 32'hDEAD_BEEF, 2);
        do_write(32'h13F, 32'h0BAD_F00D, 2);
        do_read(32'h100, 32'hDEAD_BEEF, 2);
        do_read(32'h13F, 32'h0BAD_F00D, 2);
        @(negedge clk);
        check("b_err_clean", {31'd0, m_err}, 32'd0);
        @(posedge clk);
        #1;

        // x-load pattern (8 reads) plus y-store (1 write), then reads below base
        do_reset();
        for (int i = 0; i < 8; i++) do_read(32'h100, 32'hDEAD_BEEF, 2);
        do_write(32'h101, 32'h1234_5678, 2);
        do_read(32'h101, 32'h1234_5678, 2);
        do_read(32'h0FF, 32'h0, 2);
        @(negedge clk);
        check("b_err_below_base", {31'd0, m_err}, 32'd1);
`ifdef AVMM_SLV_CNT_EN
        check("b_rcnt", {16'd0, rcnt_b}, 32'd9);
        check("b_wcnt", {16'd0, wcnt_b}, 32'd1);
`endif
        @(posedge clk);
        #1;

        repeat (3) @(posedge clk);
        check("rd_queue_drained", 32'(q_rd.size()), 32'd0);
        check("wr_queue_drained", 32'(q_wr.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/avmm_sample_mem_slave.md
Name: avmm_sample_mem_slave

Overview:
- Avalon-MM style memory responder that serves the filter engine's master-read and master-write ports: the slave end of the same bus.
- Holds x samples, h coefficients and y results in one word array, reachable through two independent ports.
- Each port inserts a configurable number of wait-request cycles, so master stall handling can be exercised.
- Used in the system simulation and as the on-chip sample buffer.

Parameters:
- DATA_W, 32: data width of both ports.
- ADDR_W, 6: array index width; depth is 2**ADDR_W words.
- BASE_ADDR, 32'h00000000: word address mapped to array index 0.
- READ_WAIT, 2: extra wait cycles per read (0..15).
- WRITE_WAIT, 1: extra wait cycles per write (0..15).

Ports:
- iClk  in  1  clock
- iRst  in  1  reset
- iAddress_Read  in  32  read word address
- iRead  in  1  read request
- oReadData  out  DATA_W  read data, registered
- oWait_Read  out  1  read wait-request, combinational
- iAddress_Write  in  32  write word address
- iWrite  in  1  write request
- iWriteData  in  DATA_W  write data
- oWait_Write  out  1  write wait-request, combinational
- oErr  out  1  sticky out-of-range access flag

Behaviour:
- Interface: one clock (iClk); reset (iRst) is synchronous and active-high.
- Reset values: oReadData=0, oErr=0, both FSMs in IDLE, both wait counters 0. The array is not cleared.
- Address decode: idx = iAddress - BASE_ADDR (32-bit subtract, wraps modulo 2**32). The access is in range iff idx < 2**ADDR_W.
- Read FSM, states R_IDLE, R_WAIT, R_ACK:
  - oWait_Read = iRead && (state != R_ACK).
  - R_IDLE: if iRead, load cnt <= READ_WAIT and go to R_WAIT.
  - R_WAIT: if cnt == 0, latch oReadData <= mem[idx] (or 0 if out of range, which also sets oErr), then go to R_ACK. Otherwise decrement cnt.
  - R_ACK: oWait_Read = 0 and the transfer completes this cycle; return to R_IDLE unconditionally.
  - A read therefore holds iRead for READ_WAIT+3 cycles. oReadData is valid in R_ACK and holds until the next latch.
  - If iRead drops while in R_WAIT (a master protocol violation), abort to R_IDLE with no latch.
- Write FSM, states W_IDLE, W_WAIT, W_ACK: same structure as the read FSM, using WRITE_WAIT.
  - oWait_Write = iWrite && (state != W_ACK).
  - Commit mem[idx] <= iWriteData on the clock edge that ends W_ACK.
  - An out-of-range write is dropped and sets oErr.
  - A write holds iWrite for WRITE_WAIT+3 cycles.
- Port independence: both FSMs run concurrently. If the read latch and the write commit hit the same idx on the same edge, the read returns the old data (read-before-write).
- Back-to-back: a new request in the cycle after ACK is accepted from IDLE. No ACK-to-WAIT shortcut.
- Address and data are sampled at the latch/commit edge only. The master holds them stable while wait is high.
- oErr stays set until iRst.
- Reset mid-transfer: both FSMs return to IDLE immediately. A pending write is not committed. Array contents already written are kept.

Optional Feature:
- Macro AVMM_SLV_CNT_EN adds ports oRdCount (out, 16) and oWrCount (out, 16).
- These count completed in-range transfers (the R_ACK/W_ACK cycles), saturate at 16'hFFFF, and reset to 0.
- Without the macro, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then write 32'h0000_0012 to BASE_ADDR+3 with WRITE_WAIT=1 -> oWait_Write high for 3 cycles, low for 1; a later read of BASE_ADDR+3 returns 32'h12, with oWait_Read high 4 cycles then low 1 (READ_WAIT=2).
- READ_WAIT=0, WRITE_WAIT=0 -> read completes in 3 cycles, write in 3 cycles; data round-trips for idx 0 and idx 63.
- Read of BASE_ADDR+64 (out of range) -> oReadData=0, oErr=1. A following in-range write still succeeds and oErr stays 1.
- Concurrent read and write to idx 5: old value 32'hA, new value 32'hB, latch and commit on the same edge -> read returns 32'hA; the next read returns 32'hB.
- iRst asserted during W_WAIT of a write of 32'hFF to idx 7 -> idx 7 keeps its prior value, both waits drop, and oErr=0.
- With AVMM_SLV_CNT_EN: 8 reads plus 1 write (the full x-load pattern plus y-store) -> oRdCount=8, oWrCount=1.
